// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with iterative unsigned MUL/DIV, CMP and valid/ready handshakes
module alu_mc #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   ALU_Sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] ALU_Result,
    output logic [N-1:0] ALU_Result_Hi,
    output logic [3:0]   ALU_Flags,
    output logic         busy,
    output logic         div_by_zero
);
    localparam int CW = $clog2(N);
    localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR = 3'b011,
                           OP_MUL = 3'b100, OP_MOV = 3'b101, OP_DIV = 3'b110, OP_CMP = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  hi, lo, opb;
    logic [N-1:0]  hi_nx, lo_nx, res, fres;
    logic [N:0]    add_s, sub_s, mul_s, div_t, div_d;
    logic [3:0]    flg;
    logic          accept, dbz, iter_op, last, q_bit, c_bit, v_bit;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state == MUL_IT || state == DIV_IT;
    assign accept    = in_ready && in_valid;
    assign dbz       = ALU_Sel == OP_DIV && B == '0;
    assign iter_op   = ALU_Sel == OP_MUL || (ALU_Sel == OP_DIV && !dbz);
    assign last      = cnt == CW'(N - 1);

    // Single-cycle ops: result and {N,Z,C,V}; CMP reports SUB flags with a zero result
    always_comb begin
        add_s = {1'b0, A} + {1'b0, B};
        sub_s = {1'b0, A} - {1'b0, B};
        res   = ALU_Sel == OP_ADD ? add_s[N-1:0] :
                ALU_Sel == OP_SUB ? sub_s[N-1:0] :
                ALU_Sel == OP_AND ? A & B :
                ALU_Sel == OP_OR  ? A | B :
                ALU_Sel == OP_MOV ? B : '0;
        fres  = ALU_Sel == OP_CMP ? sub_s[N-1:0] : res;
        c_bit = ALU_Sel == OP_ADD ? add_s[N] :
                (ALU_Sel == OP_SUB || ALU_Sel == OP_CMP) ? ~sub_s[N] : 1'b0;
        v_bit = ALU_Sel == OP_ADD ? (A[N-1] == B[N-1]) && (add_s[N-1] != A[N-1]) :
                (ALU_Sel == OP_SUB || ALU_Sel == OP_CMP) ? (A[N-1] != B[N-1]) && (sub_s[N-1] != A[N-1]) : 1'b0;
        flg   = {fres[N-1], fres == '0, c_bit, v_bit};
    end

    // One shift-add (MUL) or restoring-subtract (DIV) step on the {hi,lo} working pair
    always_comb begin
        mul_s = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        div_t = {hi, lo[N-1]};
        div_d = div_t - {1'b0, opb};
        q_bit = ~div_d[N];
        hi_nx = state == MUL_IT ? mul_s[N:1] : (q_bit ? div_d[N-1:0] : div_t[N-1:0]);
        lo_nx = state == MUL_IT ? {mul_s[0], lo[N-1:1]} : {lo[N-2:0], q_bit};
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:           state_nx = !in_valid ? IDLE : ALU_Sel == OP_MUL ? MUL_IT : iter_op ? DIV_IT : DONE;
            MUL_IT, DIV_IT: state_nx = last ? DONE : state;
            DONE:           state_nx = out_ready ? IDLE : DONE;
            default:        state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand latch, iteration datapath and registered result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            hi            <= '0;
            lo            <= '0;
            opb           <= '0;
            ALU_Result    <= '0;
            ALU_Result_Hi <= '0;
            ALU_Flags     <= '0;
            div_by_zero   <= 1'b0;
        end else if (accept) begin
            cnt         <= '0;
            hi          <= '0;
            lo          <= A;
            opb         <= B;
            div_by_zero <= dbz;
            if (!iter_op) begin
                ALU_Result    <= dbz ? '1 : res;
                ALU_Result_Hi <= dbz ? A : '0;
                ALU_Flags     <= dbz ? 4'b1001 : flg;
            end
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_nx;
            lo  <= lo_nx;
            if (last) begin
                ALU_Result    <= lo_nx;
                ALU_Result_Hi <= hi_nx;
                ALU_Flags     <= {lo_nx[N-1], lo_nx == '0, state == MUL_IT && hi_nx != '0, 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at N=32 and N=8
module tb_alu_mc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic [2:0]  ALU_Sel = '0;
    logic        in_ready, out_valid, busy, div_by_zero;
    logic [31:0] ALU_Result, ALU_Result_Hi;
    logic [3:0]  ALU_Flags;

    logic        v8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [2:0]  s8 = '0;
    logic        ir8, ov8, bz8, dz8;
    logic [7:0]  r8, h8;
    logic [3:0]  f8;

    int errs = 0;
    int checks = 0;
    int lat, nbusy;

    always #5 clk = ~clk;

    alu_mc #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid), .out_ready(out_ready),
        .ALU_Result(ALU_Result), .ALU_Result_Hi(ALU_Result_Hi), .ALU_Flags(ALU_Flags),
        .busy(busy), .div_by_zero(div_by_zero)
    );

    alu_mc #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
        .A(a8), .B(b8), .ALU_Sel(s8), .out_valid(ov8), .out_ready(out_ready),
        .ALU_Result(r8), .ALU_Result_Hi(h8), .ALU_Flags(f8),
        .busy(bz8), .div_by_zero(dz8)
    );

    // Issue one op, scramble the inputs after acceptance, count cycles until out_valid
    task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALU_Sel = sel; A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = ~a; B = ~b; ALU_Sel = ~sel;
        lat = 1; nbusy = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        checks++; if ({ALU_Result, ALU_Result_Hi, ALU_Flags, busy, div_by_zero} !== 70'd0) begin
            errs++; $display("FAIL reset outputs: got res=%h hi=%h fl=%b busy=%b dz=%b want all 0", ALU_Result, ALU_Result_Hi, ALU_Flags, busy, div_by_zero);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_add;
        run_op(3'b000, 32'h7FFF_FFFF, 32'h1);
        checks++; if (lat !== 1) begin errs++; $display("FAIL add latency: got %0d want 1", lat); end
        checks++; if (nbusy !== 0) begin errs++; $display("FAIL add busy: got %0d want 0", nbusy); end
        checks++; if ({ALU_Result, ALU_Result_Hi, ALU_Flags} !== {32'h8000_0000, 32'h0, 4'b1001}) begin
            errs++; $display("FAIL add ovf: got %h %h %b want 80000000 00000000 1001", ALU_Result, ALU_Result_Hi, ALU_Flags);
        end
        drain;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errs++; $display("FAIL add drain: got ov=%b ir=%b want 0 1", out_valid, in_ready); end
        run_op(3'b000, 32'hFFFF_FFFF, 32'h1);
        checks++; if ({ALU_Result, ALU_Flags} !== {32'h0, 4'b0110}) begin
            errs++; $display("FAIL add carry: got %h %b want 00000000 0110", ALU_Result, ALU_Flags);
        end
        drain;
    endtask

    task automatic test_sub_cmp;
        run_op(3'b001, 32'd5, 32'd5);
        checks++; if ({ALU_Result, ALU_Flags} !== {32'h0, 4'b0110}) begin errs++; $display("FAIL sub 5-5: got %h %b want 00000000 0110", ALU_Result, ALU_Flags); end
        drain;
        run_op(3'b001, 32'd3, 32'd5);
        checks++; if ({ALU_Result, ALU_Flags} !== {32'hFFFF_FFFE, 4'b1000}) begin errs++; $display("FAIL sub 3-5: got %h %b want fffffffe 1000", ALU_Result, ALU_Flags); end
        drain;
        run_op(3'b001, 32'h8000_0000, 32'h1);
        checks++; if ({ALU_Result, ALU_Flags} !== {32'h7FFF_FFFF, 4'b0011}) begin errs++; $display("FAIL sub ovf: got %h %b want 7fffffff 0011", ALU_Result, ALU_Flags); end
        drain;
        run_op(3'b111, 32'd5, 32'd5);
        checks++; if ({ALU_Result, ALU_Result_Hi, ALU_Flags} !== {32'h0, 32'h0, 4'b0110}) begin errs++; $display("FAIL cmp 5,5: got %h %h %b want 0 0 0110", ALU_Result, ALU_Result_Hi, ALU_Flags); end
        drain;
        run_op(3'b111, 32'd3, 32'd5);
        checks++; if ({ALU_Result, ALU_Flags} !== {32'h0, 4'b1000}) begin errs++; $display("FAIL cmp 3,5: got %h %b want 00000000 1000", ALU_Result, ALU_Flags); end
        drain;
    endtask

    task automatic test_logic;
        run_op(3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        checks++; if ({ALU_Result, ALU_Flags} !== {32'h00F0_00F0, 4'b0000}) begin errs++; $display("FAIL and: got %h %b want 00f000f0 0000", ALU_Result, ALU_Flags); end
        drain;
        run_op(3'b011, 32'h8000_0000, 32'h1);
        checks++; if ({ALU_Result, ALU_Flags} !== {32'h8000_0001, 4'b1000}) begin errs++; $display("FAIL or: got %h %b want 80000001 1000", ALU_Result, ALU_Flags); end
        drain;
        run_op(3'b101, 32'd5, 32'd0);
        checks++; if ({ALU_Result, ALU_Flags} !== {32'h0, 4'b0100}) begin errs++; $display("FAIL mov: got %h %b want 00000000 0100", ALU_Result, ALU_Flags); end
        drain;
    endtask

    task automatic test_mul;
        run_op(3'b100, 32'hFFFF_FFFF, 32'd2);
        checks++; if (lat !== 33) begin errs++; $display("FAIL mul latency: got %0d want 33", lat); end
        checks++; if (nbusy !== 32) begin errs++; $display("FAIL mul busy: got %0d want 32", nbusy); end
        checks++; if ({ALU_Result, ALU_Result_Hi, ALU_Flags} !== {32'hFFFF_FFFE, 32'h1, 4'b1010}) begin
            errs++; $display("FAIL mul: got %h %h %b want fffffffe 00000001 1010", ALU_Result, ALU_Result_Hi, ALU_Flags);
        end
        drain;
        run_op(3'b100, 32'h0001_0000, 32'h0001_0000);
        checks++; if ({ALU_Result, ALU_Result_Hi, ALU_Flags} !== {32'h0, 32'h1, 4'b0110}) begin
            errs++; $display("FAIL mul 2^32: got %h %h %b want 00000000 00000001 0110", ALU_Result, ALU_Result_Hi, ALU_Flags);
        end
        drain;
        run_op(3'b000, 32'd1, 32'd1);
        checks++; if ({ALU_Result, ALU_Result_Hi} !== {32'd2, 32'h0}) begin errs++; $display("FAIL add after mul: got %h %h want 00000002 00000000", ALU_Result, ALU_Result_Hi); end
        drain;
        @(negedge clk);
        s8 = 3'b100; a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        lat = 1;
        while (!ov8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 9) begin errs++; $display("FAIL mul8 latency: got %0d want 9", lat); end
        checks++; if ({r8, h8, f8} !== {8'h01, 8'hFE, 4'b0010}) begin errs++; $display("FAIL mul8: got %h %h %b want 01 fe 0010", r8, h8, f8); end
        drain;
    endtask

    task automatic test_div;
        run_op(3'b110, 32'd100, 32'd7);
        checks++; if (lat !== 33) begin errs++; $display("FAIL div latency: got %0d want 33", lat); end
        checks++; if ({ALU_Result, ALU_Result_Hi, ALU_Flags, div_by_zero} !== {32'd14, 32'd2, 4'b0000, 1'b0}) begin
            errs++; $display("FAIL div 100/7: got %0d %0d %b dz=%b want 14 2 0000 0", ALU_Result, ALU_Result_Hi, ALU_Flags, div_by_zero);
        end
        drain;
        run_op(3'b110, 32'h1234, 32'd0);
        checks++; if (lat !== 1) begin errs++; $display("FAIL div0 latency: got %0d want 1", lat); end
        checks++; if ({ALU_Result, ALU_Result_Hi, ALU_Flags, div_by_zero} !== {32'hFFFF_FFFF, 32'h1234, 4'b1001, 1'b1}) begin
            errs++; $display("FAIL div0: got %h %h %b dz=%b want ffffffff 00001234 1001 1", ALU_Result, ALU_Result_Hi, ALU_Flags, div_by_zero);
        end
        drain;
        run_op(3'b110, 32'hFFFF_FFFF, 32'h10);
        checks++; if ({ALU_Result, ALU_Result_Hi, ALU_Flags, div_by_zero} !== {32'h0FFF_FFFF, 32'hF, 4'b0000, 1'b0}) begin
            errs++; $display("FAIL div big: got %h %h %b dz=%b want 0fffffff 0000000f 0000 0", ALU_Result, ALU_Result_Hi, ALU_Flags, div_by_zero);
        end
        drain;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        ALU_Sel = 3'b000; A = 32'd1; B = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        ALU_Sel = 3'b001; A = 32'd10; B = 32'd3;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({out_valid, in_ready, ALU_Result, ALU_Flags} !== {1'b1, 1'b0, 32'd3, 4'b0000}) begin
                errs++; $display("FAIL hold cycle %0d: got ov=%b ir=%b %h %b want 1 0 00000003 0000", i, out_valid, in_ready, ALU_Result, ALU_Flags);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready, ALU_Result} !== {1'b0, 1'b1, 32'd3}) begin
            errs++; $display("FAIL after handshake: got ov=%b ir=%b %h want 0 1 00000003", out_valid, in_ready, ALU_Result);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if ({out_valid, ALU_Result, ALU_Flags} !== {1'b1, 32'd7, 4'b0010}) begin
            errs++; $display("FAIL second op: got ov=%b %h %b want 1 00000007 0010", out_valid, ALU_Result, ALU_Flags);
        end
        drain;
    endtask

    task automatic test_reset_mid_mul;
        @(negedge clk);
        ALU_Sel = 3'b100; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL mid-mul busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({ALU_Result, ALU_Result_Hi, ALU_Flags, out_valid, busy, div_by_zero} !== 71'd0) begin
            errs++; $display("FAIL reset mid-mul: got %h %h %b ov=%b busy=%b dz=%b want all 0", ALU_Result, ALU_Result_Hi, ALU_Flags, out_valid, busy, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({in_ready, busy, out_valid} !== 3'b100) begin errs++; $display("FAIL after reset: got ir=%b busy=%b ov=%b want 1 0 0", in_ready, busy, out_valid); end
        run_op(3'b000, 32'd2, 32'd3);
        checks++; if ({lat, ALU_Result, ALU_Result_Hi, ALU_Flags} !== {32'd1, 32'd5, 32'd0, 4'b0000}) begin
            errs++; $display("FAIL add after abort: got lat=%0d %h %h %b want 1 00000005 00000000 0000", lat, ALU_Result, ALU_Result_Hi, ALU_Flags);
        end
        drain;
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_cmp;
        test_logic;
        test_mul;
        test_div;
        test_back_to_back;
        test_reset_mid_mul;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
